dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two requesters:
  - the pipeline MEM stage (CPU port);
  - a peripheral/DMA master (DMA port, e.g. UART loader or debug unit).
- Sits between the MEM stage and the data memory instance, and drives a stall back to the pipeline when the CPU loses a cycle.
- The CPU has fixed priority; a starvation counter guarantees the DMA port a slot.

Parameters:
- ADDR_W, 32, address width of both ports and memory.
- DATA_W, 32, data width of both ports and memory.
- STARVE_MAX, 4, consecutive denied DMA cycles after which the DMA port is forced a grant (1..15).

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- cpu_rd  in  1  MEM-stage load request.
- cpu_wr  in  1  MEM-stage store request.
- cpu_addr  in  ADDR_W  CPU byte address (ALU result).
- cpu_wdata  in  DATA_W  CPU store data.
- cpu_rdata  out  DATA_W  load data; equals mem_rdata, valid in the granted cycle.
- cpu_stall  out  1  CPU request not served this cycle; the pipeline must hold MEM and earlier stages.
- dma_req  in  1  DMA request; held high with stable inputs until dma_ack.
- dma_we  in  1  1 = write, 0 = read; qualified by dma_req.
- dma_addr  in  ADDR_W  DMA address.
- dma_wdata  in  DATA_W  DMA write data.
- dma_ack  out  1  one-cycle pulse, registered, the cycle after the DMA access.
- dma_rdata  out  DATA_W  registered read data, valid while dma_ack=1 and held afterwards.
- mem_rd  out  1  to data memory rd.
- mem_wr  out  1  to data memory wr.
- mem_addr  out  ADDR_W  to data memory addr.
- mem_wdata  out  DATA_W  to data memory wdata.
- mem_rdata  in  DATA_W  from data memory; combinational read of mem_addr; writes commit at posedge.

Behaviour:
- Definitions:
  - cpu_req = cpu_rd | cpu_wr.
  - dma_pend = dma_req & ~dma_ack. The request is not serviced again in its ack cycle.
- Grant, combinational per cycle:
  - grant_dma = dma_pend & (~cpu_req | starve_cnt == STARVE_MAX).
  - grant_cpu = cpu_req & ~grant_dma.
  - cpu_stall = cpu_req & grant_dma.
- Memory mux:
  - grant_dma: mem_rd=~dma_we, mem_wr=dma_we, mem_addr=dma_addr, mem_wdata=dma_wdata.
  - grant_cpu: mem_rd=cpu_rd, mem_wr=cpu_wr, mem_addr=cpu_addr, mem_wdata=cpu_wdata.
  - Neither granted: mem_rd=0, mem_wr=0, mem_addr=0, mem_wdata=0.
- cpu_rdata = mem_rdata unconditionally. It is meaningful only when cpu_rd & ~cpu_stall. CPU latency is 0 extra cycles when granted.
- State, registered on posedge clk:
  - dma_ack <= grant_dma.
  - dma_rdata <= mem_rdata if grant_dma & ~dma_we, else hold.
  - starve_cnt (4 bits):
    - 0 if grant_dma;
    - else +1, saturating at STARVE_MAX, if dma_pend & cpu_req;
    - else hold.
- DMA latency: ack exactly 1 cycle after its grant cycle. Minimum DMA issue interval is 2 cycles, because of the ack dead cycle.
- During the dma_ack cycle the CPU is granted if requesting, and starve_cnt holds.
- Forced DMA slot: after STARVE_MAX consecutive denied cycles, the next cycle with dma_pend goes to DMA regardless of CPU. The CPU stalls exactly that one cycle.
- cpu_rd & cpu_wr both high is illegal. Both are forwarded unchanged; no checking is done.
- dma_req dropping before ack is illegal. If it drops in a non-granted cycle, the request is abandoned and starve_cnt holds.
- Reset:
  - While reset=1: mem_rd=mem_wr=0, cpu_stall=0, grant signals forced 0, so no memory write occurs in a reset cycle.
  - Next edge: dma_ack=0, dma_rdata=0, starve_cnt=0.
  - A DMA access granted in the cycle before reset rises still commits its write; its ack is lost, and the master must reissue.

Test Plan:
- Idle, then CPU store 0xDEADBEEF to 0x10, then load 0x10 → cpu_stall=0 both cycles; cpu_rdata=0xDEADBEEF in the load cycle.
- DMA read 0x10 with CPU idle → mem_rd=1 and mem_addr=0x10 in the grant cycle; dma_ack=1 and dma_rdata=0xDEADBEEF next cycle; no second grant during the ack cycle.
- CPU requests continuously and DMA write 0x55 to 0x20 is pending, STARVE_MAX=4 → 4 cycles cpu_stall=0; 5th cycle cpu_stall=1 and mem_wr with DMA address; dma_ack next cycle; starve_cnt=0.
- Simultaneous CPU load and DMA request with starve_cnt=0 → CPU served; starve_cnt increments to 1; DMA served the first cycle the CPU is idle.
- Back-to-back DMA reads with dma_req held high → grants at cycles t, t+2, t+4; ack at t+1, t+3, t+5.
- Reset asserted for 1 cycle in a DMA grant cycle → mem_wr=0 that cycle; dma_ack=0, dma_rdata=0, starve_cnt=0 after; memory at the DMA address unchanged.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares the single-port data memory between the pipeline MEM stage (CPU
//   port) and a peripheral/DMA master. The CPU has fixed priority. A
//   starvation counter forces one DMA slot after STARVE_MAX consecutive
//   denied DMA cycles, and the CPU is stalled for that one cycle.
//
// Ports
//   clk, reset             system clock, synchronous active-high reset
//   cpu_rd/wr/addr/wdata   MEM-stage request (rd and wr are forwarded as-is)
//   cpu_rdata              mem_rdata passthrough, valid when cpu_rd & ~cpu_stall
//   cpu_stall              CPU request not served this cycle
//   dma_req/we/addr/wdata  DMA request, held stable until dma_ack
//   dma_ack                registered pulse the cycle after the DMA access
//   dma_rdata              registered DMA read data, held between reads
//   mem_rd/wr/addr/wdata   to the data memory
//   mem_rdata              combinational read data from the data memory
module dmem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_ack,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  typedef struct packed {
    logic              rd;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_cmd_t;

  logic [3:0] starve_cnt;
  logic       cpu_req;
  logic       dma_pend;
  logic       starved;
  logic       grant_dma;
  logic       grant_cpu;
  mem_cmd_t   cpu_cmd;
  mem_cmd_t   dma_cmd;
  mem_cmd_t   mem_cmd;

  // ---------------------------------------------------------------- grant
  // A request sitting in its ack cycle is already served, so it does not
  // compete again; this gives the 2-cycle minimum DMA issue interval.
  always_comb begin
    cpu_req   = cpu_rd | cpu_wr;
    dma_pend  = dma_req & ~dma_ack;
    starved   = (starve_cnt == STARVE_LIM);
    // Grants are gated by reset so no memory write can occur in a reset cycle.
    grant_dma = ~reset & dma_pend & (~cpu_req | starved);
    grant_cpu = ~reset & cpu_req & ~grant_dma;
    cpu_stall = cpu_req & grant_dma;
  end

  // ----------------------------------------------------------- memory mux
  always_comb begin
    cpu_cmd = '{rd: cpu_rd, wr: cpu_wr, addr: cpu_addr, wdata: cpu_wdata};
    dma_cmd = '{rd: ~dma_we, wr: dma_we, addr: dma_addr, wdata: dma_wdata};
    mem_cmd = '0;
    if (grant_dma)      mem_cmd = dma_cmd;
    else if (grant_cpu) mem_cmd = cpu_cmd;
  end

  assign mem_rd    = mem_cmd.rd;
  assign mem_wr    = mem_cmd.wr;
  assign mem_addr  = mem_cmd.addr;
  assign mem_wdata = mem_cmd.wdata;

  // The CPU reads in the granted cycle with no extra latency.
  assign cpu_rdata = mem_rdata;

  // ---------------------------------------------------------------- state
  always_ff @(posedge clk) begin
    if (reset) begin
      dma_ack    <= 1'b0;
      dma_rdata  <= '0;
      starve_cnt <= '0;
    end else begin
      dma_ack <= grant_dma;
      if (grant_dma && !dma_we)
        dma_rdata <= mem_rdata;
      // Count only cycles where DMA competes and loses to the CPU; an
      // abandoned request or the ack cycle leaves the count alone.
      if (grant_dma)
        starve_cnt <= '0;
      else if (dma_pend && cpu_req && starve_cnt < STARVE_LIM)
        starve_cnt <= starve_cnt + 4'd1;
    end
  end

endmodule
